// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester (CPU/DBG) and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 16
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDRWIDTH-1:0] cpu_addr;
  logic [DATAWIDTH-1:0] cpu_wdata;
  logic                 cpu_gnt;
  logic                 cpu_done;
  logic [DATAWIDTH-1:0] cpu_rdata;
  logic                 dbg_req;
  logic                 dbg_we;
  logic [ADDRWIDTH-1:0] dbg_addr;
  logic [DATAWIDTH-1:0] dbg_wdata;
  logic                 dbg_gnt;
  logic                 dbg_done;
  logic [DATAWIDTH-1:0] dbg_rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic [DATAWIDTH-1:0] mem_rdata;
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    output dbg_gnt, dbg_done, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between CPU and DBG, one access in flight.
module mem_port_arbiter #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 16,
  parameter int MEM_LAT   = 1
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT + 1);
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 we_q, we_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATAWIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                 pick;
  logic                 busy;
  // owner encoding: 0 = CPU, 1 = DBG; on contention the port that did not go last wins
  assign pick = (bus.cpu_req && bus.dbg_req) ? ~last_q : bus.dbg_req;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: if (bus.cpu_req || bus.dbg_req) begin
        owner_d = pick;
        we_d    = pick ? bus.dbg_we    : bus.cpu_we;
        addr_d  = pick ? bus.dbg_addr  : bus.cpu_addr;
        wdata_d = pick ? bus.dbg_wdata : bus.cpu_wdata;
        cnt_d   = CW'(MEM_LAT - 1);
        state_d = BUSY;
      end
      BUSY: if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        cpu_rdata_d = (!we_q && !owner_q) ? bus.mem_rdata : cpu_rdata_q;
        dbg_rdata_d = (!we_q &&  owner_q) ? bus.mem_rdata : dbg_rdata_q;
        state_d     = DONE;
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy          = state_q == BUSY;
  assign bus.mem_en    = busy;
  assign bus.mem_we    = busy && we_q;
  assign bus.mem_addr  = busy ? addr_q  : '0;
  assign bus.mem_wdata = busy ? wdata_q : '0;
  assign bus.cpu_gnt   = busy && !owner_q;
  assign bus.dbg_gnt   = busy &&  owner_q;
  assign bus.cpu_done  = state_q == DONE && !owner_q;
  assign bus.dbg_done  = state_q == DONE &&  owner_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus random stimulus checked against a transaction-timeline model.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  mem_port_arbiter_if #(.DATAWIDTH(16), .ADDRWIDTH(16)) bus ();
  mem_port_arbiter #(.DATAWIDTH(16), .ADDRWIDTH(16), .MEM_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [15:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // model: m_t is cycles since issue (0 idle, 1..LAT on the bus, LAT+1 done pulse)
  int          m_t;
  logic        m_owner;
  logic        m_last;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rd [2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_t     = 0;
    m_owner = 1'b0;
    m_last  = 1'b1;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rd[0] = '0;
    m_rd[1] = '0;
  endtask
  task automatic model_edge();
    if (m_t == 0) begin
      if (bus.cpu_req || bus.dbg_req) begin
        m_owner = (bus.cpu_req && bus.dbg_req) ? !m_last : bus.dbg_req;
        m_we    = m_owner ? bus.dbg_we    : bus.cpu_we;
        m_addr  = m_owner ? bus.dbg_addr  : bus.cpu_addr;
        m_wdata = m_owner ? bus.dbg_wdata : bus.cpu_wdata;
        m_t     = 1;
      end
    end else if (m_t <= LAT) begin
      if (m_t == LAT && !m_we) m_rd[m_owner] = mem[m_addr[7:0]];
      m_t++;
    end else begin
      m_last = m_owner;
      m_t    = 0;
    end
  endtask
  task automatic check_all(input string tag);
    logic on;
    logic dn;
    on = m_t >= 1 && m_t <= LAT;
    dn = m_t == LAT + 1;
    chk({tag, "_mem_en"},    32'(bus.mem_en),    32'(on));
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'(on && m_we));
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'(on ? m_addr : 16'h0));
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(on ? m_wdata : 16'h0));
    chk({tag, "_cpu_gnt"},   32'(bus.cpu_gnt),   32'(on && !m_owner));
    chk({tag, "_dbg_gnt"},   32'(bus.dbg_gnt),   32'(on && m_owner));
    chk({tag, "_cpu_done"},  32'(bus.cpu_done),  32'(dn && !m_owner));
    chk({tag, "_dbg_done"},  32'(bus.dbg_done),  32'(dn && m_owner));
    chk({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'(m_rd[0]));
    chk({tag, "_dbg_rdata"}, 32'(bus.dbg_rdata), 32'(m_rd[1]));
  endtask
  // memory block writes on the edge that ends each mem_en&mem_we cycle
  task automatic tick(input string tag);
    logic        wr;
    logic [7:0]  wa;
    logic [15:0] wd;
    wr = bus.mem_en && bus.mem_we;
    wa = bus.mem_addr[7:0];
    wd = bus.mem_wdata;
    model_edge();
    @(posedge clk);
    if (wr) mem[wa] = wd;
    #1;
    check_all(tag);
  endtask
  task automatic set_cpu(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask
  task automatic set_dbg(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask
  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all(tag);
    rst = 1'b0;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'hBEEF;
    mem[8'h20] = 16'h1357;
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    do_reset("reset");
    tick("idle");
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    tick("t1_b1");
    chk("t1_en_first", 32'(bus.mem_en), 32'd1);
    tick("t1_b2");
    tick("t1_done");
    chk("t1_cpu_done", 32'(bus.cpu_done), 32'd1);
    chk("t1_rdata", 32'(bus.cpu_rdata), 32'hBEEF);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    tick("t1_idle");
    chk("t1_done_once", 32'(bus.cpu_done), 32'd0);
    do_reset("t2_reset");
    set_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
    set_dbg(1'b1, 1'b0, 16'h0010, 16'h0);
    for (int k = 0; k < 16; k++) begin
      tick("t2");
      chk("t2_cpu_done_order", 32'(bus.cpu_done), 32'(k % 8 == 2));
      chk("t2_dbg_done_order", 32'(bus.dbg_done), 32'(k % 8 == 6));
      chk("t2_bubble", 32'(bus.mem_en), 32'(k % 4 < 2));
    end
    chk("t2_dbg_rdata", 32'(bus.dbg_rdata), 32'hBEEF);
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    tick("t2_drain");
    tick("t2_drain");
    set_dbg(1'b1, 1'b1, 16'h00FF, 16'h1234);
    tick("t3_b1");
    chk("t3_mem_we", 32'(bus.mem_we), 32'd1);
    chk("t3_mem_addr", 32'(bus.mem_addr), 32'h00FF);
    chk("t3_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
    tick("t3_b2");
    chk("t3_mem_wdata2", 32'(bus.mem_wdata), 32'h1234);
    tick("t3_done");
    chk("t3_dbg_done", 32'(bus.dbg_done), 32'd1);
    chk("t3_dbg_rdata_kept", 32'(bus.dbg_rdata), 32'hBEEF);
    set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    tick("t3_idle");
    chk("t3_mem_written", 32'(mem[8'hFF]), 32'h1234);
    set_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
    tick("t4_b1");
    set_cpu(1'b1, 1'b1, 16'h0AAA, 16'h5555);
    tick("t4_b2");
    chk("t4_addr_held", 32'(bus.mem_addr), 32'h0020);
    chk("t4_we_held", 32'(bus.mem_we), 32'd0);
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    tick("t6_done");
    chk("t4_rdata", 32'(bus.cpu_rdata), 32'h1357);
    tick("t6_bubble");
    chk("t6_bubble_gnt", 32'(bus.cpu_gnt), 32'd0);
    tick("t6_regrant");
    chk("t6_regrant_gnt", 32'(bus.cpu_gnt), 32'd1);
    tick("t6_b2");
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    tick("t6_done2");
    chk("t6_rdata2", 32'(bus.cpu_rdata), 32'hBEEF);
    tick("t6_idle");
    set_cpu(1'b1, 1'b0, 16'h0030, 16'h0);
    tick("t5_busy");
    #2 rst = 1'b1;
    #1;
    chk("t5_async_en", 32'(bus.mem_en), 32'd0);
    chk("t5_async_gnt", 32'(bus.cpu_gnt), 32'd0);
    chk("t5_async_rdata", 32'(bus.cpu_rdata), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    tick("t5_nodone");
    tick("t5_nodone2");
    set_cpu(1'b1, 1'b0, 16'h0040, 16'h0);
    set_dbg(1'b1, 1'b0, 16'h0050, 16'h0);
    tick("t5_rr");
    chk("t5_cpu_first", 32'(bus.cpu_gnt), 32'd1);
    for (int n = 0; n < 600; n++) begin
      set_cpu($urandom_range(0, 3) != 0, 1'($urandom), {12'h0, 4'($urandom)}, 16'($urandom));
      set_dbg($urandom_range(0, 3) != 0, 1'($urandom), {12'h0, 4'($urandom)}, 16'($urandom));
      tick("rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
